// File: rtl/bus_round_robin_arbiter.sv
// bus_round_robin_arbiter
// Shares one system bus between NUM_MASTERS masters. A requester picked
// round-robin receives a single-cycle grant pulse. The arbiter then follows
// the owner's begin/end of transaction until the bus is free again. Two
// watchdogs guard the bus. The first silently withdraws a grant that is never
// used. The second aborts a transaction that shows no activity, pulsing
// end_transaction_out and bus_error_out.

module bus_round_robin_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int BEGIN_TIMEOUT  = 8,
  parameter int ACTIVE_TIMEOUT = 256
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_MASTERS-1:0]         request,
  output logic [NUM_MASTERS-1:0]         granted,
  input  logic                           begin_transaction_in,
  input  logic                           end_transaction_in,
  input  logic                           data_valid_in,
  input  logic                           busy_in,
  input  logic                           error_in,
  output logic                           end_transaction_out,
  output logic                           bus_error_out,
  output logic [$clog2(NUM_MASTERS)-1:0] active_master,
  output logic                           bus_idle
);

  localparam int IDX_W       = $clog2(NUM_MASTERS);
  localparam int MAX_TIMEOUT = (BEGIN_TIMEOUT > ACTIVE_TIMEOUT) ? BEGIN_TIMEOUT : ACTIVE_TIMEOUT;
  localparam int CNT_W       = $clog2(MAX_TIMEOUT) + 1;

  localparam logic [CNT_W-1:0] BEGIN_LAST  = CNT_W'(BEGIN_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ACTIVE_LAST = CNT_W'(ACTIVE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [IDX_W-1:0] PTR_RESET   = IDX_W'(NUM_MASTERS - 1);

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    WAIT_BEGIN,
    ACTIVE,
    ABORT
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] next_count;
  logic [CNT_W-1:0] count_inc;
  logic [IDX_W-1:0] pointer;
  logic [IDX_W-1:0] next_pointer;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] next_owner;
  logic [IDX_W-1:0] sel;
  logic             sel_valid;
  int               scan_idx;

  // Round-robin pick: first requester found scanning upward from pointer+1, wrapping at NUM_MASTERS
  always_comb begin
    sel       = '0;
    sel_valid = 1'b0;
    scan_idx  = 0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      scan_idx = (int'(pointer) + i) % NUM_MASTERS;
      if (!sel_valid && request[IDX_W'(scan_idx)]) begin
        sel       = IDX_W'(scan_idx);
        sel_valid = 1'b1;
      end
    end
  end

  // Watchdog counter saturates at all-ones so a long wait can never wrap back to a small count
  always_comb begin
    count_inc = (count == CNT_MAX) ? count : count + 1'b1;
  end

  // State register together with the watchdog counter, round-robin pointer and owner index
  always_ff @(posedge clock) begin
    if (!reset) begin
      state   <= IDLE;
      count   <= '0;
      pointer <= PTR_RESET;
      owner   <= '0;
    end else begin
      state   <= next_state;
      count   <= next_count;
      pointer <= next_pointer;
      owner   <= next_owner;
    end
  end

  // Next-state logic: a real end of transaction always takes priority over either timeout
  always_comb begin
    next_state   = state;
    next_count   = count;
    next_pointer = pointer;
    next_owner   = owner;
    case (state)
      IDLE: begin
        if (sel_valid) begin
          next_state   = GRANT;
          next_pointer = sel;
          next_owner   = sel;
          next_count   = '0;
        end
      end
      GRANT: begin
        next_state = WAIT_BEGIN;
        next_count = '0;
      end
      WAIT_BEGIN: begin
        if (begin_transaction_in && end_transaction_in) begin
          next_state = IDLE;
        end else if (begin_transaction_in) begin
          next_state = ACTIVE;
          next_count = '0;
        end else if (count >= BEGIN_LAST) begin
          next_state = IDLE;
        end else begin
          next_count = count_inc;
        end
      end
      ACTIVE: begin
        if (end_transaction_in || error_in) begin
          next_state = IDLE;
        end else if (data_valid_in || busy_in) begin
          next_count = '0;
        end else if (count >= ACTIVE_LAST) begin
          next_state = ABORT;
        end else begin
          next_count = count_inc;
        end
      end
      ABORT: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Outputs decode the registered state only, so each pulse lasts exactly one state cycle
  always_comb begin
    granted = '0;
    if (state == GRANT) begin
      granted[owner] = 1'b1;
    end
    end_transaction_out = (state == ABORT);
    bus_error_out       = (state == ABORT);
    active_master       = owner;
    bus_idle            = (state == IDLE);
  end

endmodule

// File: tb/tb_bus_round_robin_arbiter.sv
// tb_bus_round_robin_arbiter
// Directed bench for the round-robin bus arbiter. A vector table covers reset
// and the basic round-robin rotation. Hand-written sequences then cover the
// burst, begin-timeout, activity-timeout, simultaneous-event and reset-abort
// corner cases.

module tb_bus_round_robin_arbiter;

  localparam int NM = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] request;
  logic [3:0] granted;
  logic       begin_transaction_in;
  logic       end_transaction_in;
  logic       data_valid_in;
  logic       busy_in;
  logic       error_in;
  logic       end_transaction_out;
  logic       bus_error_out;
  logic [1:0] active_master;
  logic       bus_idle;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic       beg;
    logic       endt;
    logic       dv;
    logic       bsy;
    logic       err;
    logic [3:0] exp_granted;
    logic [1:0] exp_am;
    logic       exp_idle;
  } vec_t;

  vec_t vectors[$];

  bus_round_robin_arbiter #(
    .NUM_MASTERS   (NM),
    .BEGIN_TIMEOUT (8),
    .ACTIVE_TIMEOUT(256)
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .request             (request),
    .granted             (granted),
    .begin_transaction_in(begin_transaction_in),
    .end_transaction_in  (end_transaction_in),
    .data_valid_in       (data_valid_in),
    .busy_in             (busy_in),
    .error_in            (error_in),
    .end_transaction_out (end_transaction_out),
    .bus_error_out       (bus_error_out),
    .active_master       (active_master),
    .bus_idle            (bus_idle)
  );

  // Free-running 10 ns clock
  always #5 clock = ~clock;

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic r, input logic [3:0] q, input logic b, input logic e,
                       input logic d, input logic bs, input logic er);
    reset                = r;
    request              = q;
    begin_transaction_in = b;
    end_transaction_in   = e;
    data_valid_in        = d;
    busy_in              = bs;
    error_in             = er;
  endtask

  task automatic applyStimulus(input vec_t v);
    drive(v.rst_n, v.req, v.beg, v.endt, v.dv, v.bsy, v.err);
    cycle();
  endtask

  task automatic checkOutput(input string name, input logic [3:0] eg, input logic eeto,
                             input logic eberr, input logic [1:0] eam, input logic eidle);
    logic [8:0] act;
    logic [8:0] exp;
    act = {granted, end_transaction_out, bus_error_out, active_master, bus_idle};
    exp = {eg, eeto, eberr, eam, eidle};
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got granted=%b eto=%b berr=%b am=%0d idle=%b, expected granted=%b eto=%b berr=%b am=%0d idle=%b",
               name, granted, end_transaction_out, bus_error_out, active_master, bus_idle,
               eg, eeto, eberr, eam, eidle);
    end
  endtask

  task automatic add_vec(input logic r, input logic [3:0] q, input logic b, input logic e,
                         input logic [3:0] eg, input logic [1:0] eam, input logic eidle);
    vec_t v;
    v.rst_n       = r;
    v.req         = q;
    v.beg         = b;
    v.endt        = e;
    v.dv          = 1'b0;
    v.bsy         = 1'b0;
    v.err         = 1'b0;
    v.exp_granted = eg;
    v.exp_am      = eam;
    v.exp_idle    = eidle;
    vectors.push_back(v);
  endtask

  // Holds reset low for two cycles with the given requests, then releases it with all inputs quiet
  task automatic do_reset(input string name, input logic [3:0] q);
    drive(1'b0, q, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    checkOutput(name, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b1);
    cycle();
    drive(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // From IDLE: grant master m, pass through WAIT_BEGIN, then begin so the bus is ACTIVE
  task automatic open_transaction(input string name, input logic [3:0] q, input logic [1:0] m);
    logic [3:0] onehot;
    onehot = 4'b0001 << m;
    drive(1'b1, q, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    checkOutput({name, "_grant"}, onehot, 1'b0, 1'b0, m, 1'b0);
    drive(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    checkOutput({name, "_wait"}, 4'b0000, 1'b0, 1'b0, m, 1'b0);
    drive(1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    checkOutput({name, "_active"}, 4'b0000, 1'b0, 1'b0, m, 1'b0);
    drive(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int         order[4];
    logic [3:0] req_k;
    drive(1'b0, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Table: reset held two cycles, release gives master 0, then rotation 1, 3, 0 on request 1011
    order = '{0, 1, 3, 0};
    add_vec(1'b0, 4'b1111, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b1);
    add_vec(1'b0, 4'b1111, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      req_k = (k == 0) ? 4'b1111 : 4'b1011;
      add_vec(1'b1, req_k,   1'b0, 1'b0, 4'b0001 << order[k], 2'(order[k]), 1'b0);
      add_vec(1'b1, 4'b1011, 1'b0, 1'b0, 4'b0000, 2'(order[k]), 1'b0);
      add_vec(1'b1, 4'b1011, 1'b0, 1'b0, 4'b0000, 2'(order[k]), 1'b0);
      add_vec(1'b1, 4'b1011, 1'b1, 1'b0, 4'b0000, 2'(order[k]), 1'b0);
      add_vec(1'b1, 4'b1011, 1'b0, 1'b0, 4'b0000, 2'(order[k]), 1'b0);
      add_vec(1'b1, 4'b1011, 1'b0, 1'b0, 4'b0000, 2'(order[k]), 1'b0);
      add_vec(1'b1, 4'b1011, 1'b0, 1'b1, 4'b0000, 2'(order[k]), 1'b1);
    end
    add_vec(1'b1, 4'b1011, 1'b0, 1'b0, 4'b0001, 2'd0, 1'b0);

    foreach (vectors[i]) begin
      applyStimulus(vectors[i]);
      checkOutput($sformatf("vec%0d", i), vectors[i].exp_granted, 1'b0, 1'b0,
                  vectors[i].exp_am, vectors[i].exp_idle);
    end

    // DMA burst on master 2 while the others keep requesting
    do_reset("burst_reset", 4'b0000);
    drive(1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    checkOutput("burst_grant", 4'b0100, 1'b0, 1'b0, 2'd2, 1'b0);
    drive(1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    checkOutput("burst_wait", 4'b0000, 1'b0, 1'b0, 2'd2, 1'b0);
    drive(1'b1, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    checkOutput("burst_active", 4'b0000, 1'b0, 1'b0, 2'd2, 1'b0);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 4'b1111, 1'b0, 1'b0, !(i == 4 || i == 5), 1'b0, 1'b0);
      cycle();
      checkOutput($sformatf("burst_data%0d", i), 4'b0000, 1'b0, 1'b0, 2'd2, 1'b0);
    end
    drive(1'b1, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle();
    checkOutput("burst_end", 4'b0000, 1'b0, 1'b0, 2'd2, 1'b1);
    drive(1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    checkOutput("burst_next_grant", 4'b1000, 1'b0, 1'b0, 2'd3, 1'b0);

    // Grant never used: eight cycles in WAIT_BEGIN, silent return to IDLE, next requester served
    do_reset("nobegin_reset", 4'b0000);
    drive(1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    checkOutput("nobegin_grant", 4'b0010, 1'b0, 1'b0, 2'd1, 1'b0);
    drive(1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    checkOutput("nobegin_wait", 4'b0000, 1'b0, 1'b0, 2'd1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cycle();
      checkOutput($sformatf("nobegin_tick%0d", i), 4'b0000, 1'b0, 1'b0, 2'd1, i == 7);
    end
    cycle();
    checkOutput("nobegin_next_grant", 4'b0100, 1'b0, 1'b0, 2'd2, 1'b0);

    // Stuck transaction: 256 quiet cycles in ACTIVE produce one abort pulse
    do_reset("stuck_reset", 4'b0000);
    open_transaction("stuck", 4'b0001, 2'd0);
    for (int i = 1; i <= 256; i++) begin
      cycle();
      checkOutput($sformatf("stuck_tick%0d", i), 4'b0000, i == 256, i == 256, 2'd0, 1'b0);
    end
    cycle();
    checkOutput("stuck_after_abort", 4'b0000, 1'b0, 1'b0, 2'd0, 1'b1);

    // End arriving on the very cycle the activity timeout is reached wins over the abort
    open_transaction("race", 4'b0001, 2'd0);
    repeat (255) cycle();
    checkOutput("race_still_active", 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
    drive(1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle();
    checkOutput("race_end_wins", 4'b0000, 1'b0, 1'b0, 2'd0, 1'b1);

    // A busy cycle restarts the activity watchdog
    open_transaction("busy", 4'b0001, 2'd0);
    repeat (200) cycle();
    drive(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle();
    drive(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (200) cycle();
    checkOutput("busy_keeps_alive", 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
    drive(1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle();
    checkOutput("busy_end", 4'b0000, 1'b0, 1'b0, 2'd0, 1'b1);

    // error_in with end_transaction_in closes the bus once, no abort pulse
    open_transaction("err_end", 4'b0001, 2'd0);
    drive(1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle();
    checkOutput("err_end_idle", 4'b0000, 1'b0, 1'b0, 2'd0, 1'b1);
    drive(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    checkOutput("err_end_no_pulse", 4'b0000, 1'b0, 1'b0, 2'd0, 1'b1);

    // Reset in the middle of a transaction returns every output to its reset value
    open_transaction("midreset", 4'b0010, 2'd1);
    drive(1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle();
    checkOutput("midreset_outputs", 4'b0000, 1'b0, 1'b0, 2'd0, 1'b1);

    // Sole requester 3 with a zero-length transaction is granted again on its next turn
    drive(1'b1, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    checkOutput("sole_grant1", 4'b1000, 1'b0, 1'b0, 2'd3, 1'b0);
    cycle();
    checkOutput("sole_wait", 4'b0000, 1'b0, 1'b0, 2'd3, 1'b0);
    drive(1'b1, 4'b1000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle();
    checkOutput("zero_length_idle", 4'b0000, 1'b0, 1'b0, 2'd3, 1'b1);
    drive(1'b1, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    checkOutput("sole_grant2", 4'b1000, 1'b0, 1'b0, 2'd3, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
